// File: rtl/mem_pkg.sv
// Shared types and constants for the single-port scratch memory.
package mem_pkg;

  // Deepest read pipeline the memory supports.
  localparam int MAX_RD_LATENCY = 4;

  // Controller state: clearing the array after reset, or serving requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Byte-lane count for a data word width.
  function automatic int strb_width(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line: valid, data and a per-read flag travel together.
// Data stages only load on a valid beat, so the last stage holds the most
// recent read result while no read is returning. The flag is not held.
module mem_rd_pipe #(
  parameter int DW     = 16,
  parameter int STAGES = 1
) (
  input  logic          i_clk,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  input  logic          i_flg,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  output logic          o_flg
);

  logic [STAGES:1]         r_vld_pipe;
  logic [STAGES:1]         r_flg_pipe;
  logic [STAGES:1][DW-1:0] r_dat_pipe;

  // Shift valid/flag every cycle; advance data only behind a valid beat.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_vld_pipe <= '0;
      r_flg_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      r_flg_pipe[1] <= i_vld & i_flg;
      if (i_vld) r_dat_pipe[1] <= i_dat;
      for (int s = 2; s <= STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_flg_pipe[s] <= r_flg_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[STAGES];
  assign o_dat = r_dat_pipe[STAGES];
  assign o_flg = r_flg_pipe[STAGES];

endmodule

// File: rtl/mem_sp_pipe.sv
// Single-port word memory with byte strobes, registered read latency and a
// sequential post-reset clear. Optional per-word even parity is enabled with
// the MEM_PARITY_EN macro; without it perr_o is constant 0.
module mem_sp_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int STRB_WIDTH = strb_width(WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wr_rd_en_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  init_done_o,
  output logic                  perr_o
);

  // Out-of-range latency settings are pulled back into the supported window.
  localparam int LAT = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                       (RD_LATENCY < 1)              ? 1 : RD_LATENCY;

`ifdef MEM_PARITY_EN
  localparam int MW = WIDTH + 1;   // parity bit sits above the data
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  logic [MW-1:0]         r_mem [DEPTH];
  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic                  r_init_done;

  logic                  w_acc;
  logic                  w_in_rng;
  logic                  w_clr_we;
  logic [MW-1:0]         w_cur;
  logic [WIDTH-1:0]      w_merged;
  logic [MW-1:0]         w_word_wr;
  logic                  w_flg;

  // Reset beats any request presented in the same cycle.
  assign w_acc    = valid_i & r_ready & ~rst_i;
  assign w_in_rng = {1'b0, addr_i} < DEPTH_L;
  assign w_clr_we = (r_state == INIT) & ~rst_i;
  assign w_cur    = w_in_rng ? r_mem[addr_i] : '0;

  // Merge strobed lanes over the currently stored word.
  always_comb begin
    w_merged = w_cur[WIDTH-1:0];
    for (int n = 0; n < STRB_WIDTH; n++) begin
      if (wstrb_i[n]) w_merged[8*n +: 8] = wdata_i[8*n +: 8];
    end
  end

`ifdef MEM_PARITY_EN
  assign w_word_wr = {^w_merged, w_merged};
  // Out-of-range reads see an all-zero word, whose parity always matches.
  assign w_flg     = (^w_cur[WIDTH-1:0]) != w_cur[WIDTH];
`else
  assign w_word_wr = w_merged;
  assign w_flg     = 1'b0;
`endif

  // Array writes: clear sweep during INIT, strobed writes during RUN.
  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_acc & wr_rd_en_i & w_in_rng) begin
      r_mem[addr_i] <= w_word_wr;
    end
  end

  // Controller: sweep every word to zero, then open the port for good.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= INIT;
      r_clr_cnt   <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_clr_cnt == LAST) begin
            r_state     <= RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // Read data is captured at the accept edge and delayed LAT stages.
  mem_rd_pipe #(
    .DW     (WIDTH),
    .STAGES (LAT)
  ) u_rd_pipe (
    .i_clk   (clk_i),
    .i_flush (rst_i),
    .i_vld   (w_acc & ~wr_rd_en_i),
    .i_dat   (w_cur[WIDTH-1:0]),
    .i_flg   (w_flg),
    .o_vld   (rvalid_o),
    .o_dat   (rdata_o),
    .o_flg   (perr_o)
  );

  assign ready_o     = r_ready;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_mem_sp_pipe.sv
// Directed bench for mem_sp_pipe. Two instances: A (64 words, latency 1) and
// B (48 words, latency 3). Reads push their expected result and due cycle
// into a per-instance queue; a negedge monitor pops on every rvalid_o.
module tb_mem_sp_pipe;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst;
  logic [1:0]       v;
  logic [1:0]       wr;
  logic [1:0][5:0]  addr;
  logic [1:0][15:0] wd;
  logic [1:0][1:0]  st;

  logic        a_rdy, a_rv, a_idn, a_pe;
  logic [15:0] a_rd;
  logic        b_rdy, b_rv, b_idn, b_pe;
  logic [15:0] b_rd;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_sp_pipe #(.WIDTH(16), .DEPTH(64), .RD_LATENCY(1)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .valid_i(v[0]), .addr_i(addr[0]),
    .wdata_i(wd[0]), .wstrb_i(st[0]), .wr_rd_en_i(wr[0]),
    .ready_o(a_rdy), .rdata_o(a_rd), .rvalid_o(a_rv),
    .init_done_o(a_idn), .perr_o(a_pe)
  );

  mem_sp_pipe #(.WIDTH(16), .DEPTH(48), .RD_LATENCY(3)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .valid_i(v[1]), .addr_i(addr[1]),
    .wdata_i(wd[1]), .wstrb_i(st[1]), .wr_rd_en_i(wr[1]),
    .ready_o(b_rdy), .rdata_o(b_rd), .rvalid_o(b_rv),
    .init_done_o(b_idn), .perr_o(b_pe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request for one cycle; reads register their expectation.
  task automatic op(input int d, input logic w, input logic [5:0] a,
                    input logic [15:0] dat, input logic [1:0] s,
                    input logic [15:0] ex, input logic ep);
    exp_t e;
    v[d] = 1'b1; wr[d] = w; addr[d] = a; wd[d] = dat; st[d] = s;
    if (!w) begin
      e.data = ex; e.perr = ep; e.due = cyc + ((d == 0) ? 1 : 3);
      if (d == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic mon(input int d, input logic rvl, input logic [15:0] dat, input logic per);
    exp_t e;
    if (rvl !== 1'b1) return;
    if (((d == 0) ? q_a.size() : q_b.size()) == 0) begin
      n_tests++; n_fail++;
      $display("FAIL rvalid_unexp dut%0d: rvalid=1 at cycle %0d, expected no return", d, cyc);
      return;
    end
    e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
    chk($sformatf("rd_cycle_dut%0d", d), cyc, e.due);
    chk($sformatf("rd_data_dut%0d", d), {16'h0, dat}, {16'h0, e.data});
    chk($sformatf("rd_perr_dut%0d", d), {31'h0, per}, {31'h0, e.perr});
  endtask

  always @(negedge clk) begin
    mon(0, a_rv, a_rd, a_pe);
    mon(1, b_rv, b_rd, b_pe);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int rel, ra, rb;
    rst = 2'b11; v = '0; wr = '0; addr = '0; wd = '0; st = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_a",  a_rdy, 0);
    chk("rst_rvalid_a", a_rv,  0);
    chk("rst_rdata_a",  a_rd,  0);
    chk("rst_idone_a",  a_idn, 0);
    chk("rst_perr_a",   a_pe,  0);
    chk("rst_ready_b",  b_rdy, 0);

    // Release reset; ready must rise exactly DEPTH cycles later.
    rst = 2'b00; rel = cyc; ra = -1; rb = -1;
    for (int n = 0; n < 200 && (ra < 0 || rb < 0); n++) begin
      @(negedge clk);
      if (ra < 0 && a_rdy === 1'b1) begin ra = cyc; chk("idone_a", a_idn, 1); end
      if (rb < 0 && b_rdy === 1'b1) begin rb = cyc; chk("idone_b", b_idn, 1); end
    end
    chk("init_cycles_a", ra - rel, 64);
    chk("init_cycles_b", rb - rel, 48);
    @(posedge clk); #1;

    // Whole array reads back as zero.
    for (int i = 0; i < 64; i++) op(0, 1'b0, 6'(i), 16'h0, 2'b00, 16'h0000, 1'b0);

    // Strobed writes, no-op write, write then immediate read.
    op(0, 1'b1, 6'd5, 16'hA5C3, 2'b11, 16'h0, 1'b0);
    op(0, 1'b1, 6'd5, 16'h00FF, 2'b10, 16'h0, 1'b0);
    op(0, 1'b0, 6'd5, 16'h0,    2'b00, 16'h00C3, 1'b0);
    op(0, 1'b1, 6'd5, 16'hFFFF, 2'b00, 16'h0, 1'b0);
    op(0, 1'b0, 6'd5, 16'h0,    2'b00, 16'h00C3, 1'b0);
    op(0, 1'b1, 6'd6, 16'h1234, 2'b01, 16'h0, 1'b0);
    op(0, 1'b0, 6'd6, 16'h0,    2'b00, 16'h0034, 1'b0);
    op(0, 1'b1, 6'd9, 16'hBEEF, 2'b11, 16'h0, 1'b0);
    op(0, 1'b0, 6'd9, 16'h0,    2'b00, 16'hBEEF, 1'b0);
    v[0] = 1'b0;

    // Latency-3 instance: back-to-back reads return in order, no bubbles.
    op(1, 1'b1, 6'd1, 16'h1111, 2'b11, 16'h0, 1'b0);
    op(1, 1'b1, 6'd2, 16'h2222, 2'b11, 16'h0, 1'b0);
    op(1, 1'b1, 6'd3, 16'h3333, 2'b11, 16'h0, 1'b0);
    op(1, 1'b0, 6'd1, 16'h0,    2'b00, 16'h1111, 1'b0);
    op(1, 1'b0, 6'd2, 16'h0,    2'b00, 16'h2222, 1'b0);
    op(1, 1'b0, 6'd3, 16'h0,    2'b00, 16'h3333, 1'b0);
    // Last valid word vs. out-of-range addresses.
    op(1, 1'b1, 6'd47, 16'h4747, 2'b11, 16'h0, 1'b0);
    op(1, 1'b1, 6'd50, 16'hDEAD, 2'b11, 16'h0, 1'b0);
    op(1, 1'b0, 6'd47, 16'h0,    2'b00, 16'h4747, 1'b0);
    op(1, 1'b0, 6'd50, 16'h0,    2'b00, 16'h0000, 1'b0);
    op(1, 1'b0, 6'd48, 16'h0,    2'b00, 16'h0000, 1'b0);
    v[1] = 1'b0;

`ifdef MEM_PARITY_EN
    op(0, 1'b1, 6'd7, 16'h0001, 2'b11, 16'h0, 1'b0);
    v[0] = 1'b0;
    @(posedge clk); #1;
    u_a.r_mem[7][0] = ~u_a.r_mem[7][0];
    op(0, 1'b0, 6'd7, 16'h0, 2'b00, 16'h0000, 1'b1);
    op(0, 1'b0, 6'd9, 16'h0, 2'b00, 16'hBEEF, 1'b0);
    v[0] = 1'b0;
`endif

    repeat (8) @(posedge clk);
    #1;

    // Reset one cycle after a read is accepted: the read must vanish.
    v[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'd1;
    @(posedge clk); #1;
    v[1] = 1'b0; rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ready_b", b_rdy, 0);
    chk("midrst_idone_b", b_idn, 0);
    rst[1] = 1'b0; rel = cyc; rb = -1;
    // Requests while not ready are ignored.
    v[1] = 1'b1; wr[1] = 1'b0; addr[1] = 6'd2;
    for (int n = 0; n < 200 && rb < 0; n++) begin
      @(negedge clk);
      if (n == 10) v[1] = 1'b0;
      if (rb < 0 && b_rdy === 1'b1) rb = cyc;
    end
    chk("reinit_cycles_b", rb - rel, 48);
    @(posedge clk); #1;
    op(1, 1'b0, 6'd1, 16'h0, 2'b00, 16'h0000, 1'b0);
    op(1, 1'b0, 6'd2, 16'h0, 2'b00, 16'h0000, 1'b0);
    op(1, 1'b0, 6'd47, 16'h0, 2'b00, 16'h0000, 1'b0);
    v[1] = 1'b0;

    repeat (8) @(posedge clk);
    #1;
    chk("drain_q_a", q_a.size(), 0);
    chk("drain_q_b", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
